// File: rtl/alu_exec_md_if.sv
// Bus bundle between the ID/EX register and the alu_exec_md execution unit.
// master drives the decoded instruction fields; slave (the EX unit) returns results.
interface alu_exec_md_if #(
    parameter int WIDTH = 32
);
    logic             issue;
    logic [1:0]       ALUop;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       ALUctrl;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output issue, ALUop, funct, a, b,
        input  ALUctrl, result, zero, ovf, busy, stall, done, hi, lo
    );

    modport slave (
        input  issue, ALUop, funct, a, b,
        output ALUctrl, result, zero, ovf, busy, stall, done, hi, lo
    );
endinterface

// File: rtl/alu_exec_md.sv
// EX-stage ALU with integrated ALU-control decode and the HI/LO register pair.
// Define ALU_MULDIV_EN to include the iterative multiply/divide engine.
module alu_exec_md #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    alu_exec_md_if.slave bus
);

    typedef enum logic [3:0] {
        C_AND    = 4'b0000,
        C_OR     = 4'b0001,
        C_ADD    = 4'b0010,
        C_XOR    = 4'b0011,
        C_SUB    = 4'b0110,
        C_SLT    = 4'b0111,
        C_SLTU   = 4'b1000,
        C_MFHI   = 4'b1001,
        C_MFLO   = 4'b1010,
        C_MTHI   = 4'b1011,
        C_NOR    = 4'b1100,
        C_MTLO   = 4'b1101,
        C_MULDIV = 4'b1110,
        C_INV    = 4'b1111
    } ctrl_e;

    ctrl_e            ctrl;
    logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d;
    logic [WIDTH-1:0] sum, diff, res;
    logic             slt_bit, sltu_bit;
    logic             ovf_en, ovf;
    logic             busy, accept;

    always_comb begin
        ctrl = C_INV;
        case (bus.ALUop)
            2'b00: ctrl = C_ADD;
            2'b01: ctrl = C_SUB;
            2'b10: begin
                case (bus.funct)
                    6'b100000, 6'b100001: ctrl = C_ADD;
                    6'b100010, 6'b100011: ctrl = C_SUB;
                    6'b100100:            ctrl = C_AND;
                    6'b100101:            ctrl = C_OR;
                    6'b100110:            ctrl = C_XOR;
                    6'b100111:            ctrl = C_NOR;
                    6'b101010:            ctrl = C_SLT;
                    6'b101011:            ctrl = C_SLTU;
                    6'b010000:            ctrl = C_MFHI;
                    6'b010001:            ctrl = C_MTHI;
                    6'b010010:            ctrl = C_MFLO;
                    6'b010011:            ctrl = C_MTLO;
`ifdef ALU_MULDIV_EN
                    6'b011000, 6'b011001,
                    6'b011010, 6'b011011: ctrl = C_MULDIV;
`endif
                    default:              ctrl = C_INV;
                endcase
            end
            default: ctrl = C_INV;
        endcase
    end

    assign sum      = bus.a + bus.b;
    assign diff     = bus.a - bus.b;
    assign slt_bit  = ($signed(bus.a) < $signed(bus.b));
    assign sltu_bit = (bus.a < bus.b);

    always_comb begin
        res = '0;
        case (ctrl)
            C_AND:   res = bus.a & bus.b;
            C_OR:    res = bus.a | bus.b;
            C_ADD:   res = sum;
            C_XOR:   res = bus.a ^ bus.b;
            C_SUB:   res = diff;
            C_SLT:   res = {{(WIDTH-1){1'b0}}, slt_bit};
            C_SLTU:  res = {{(WIDTH-1){1'b0}}, sltu_bit};
            C_NOR:   res = ~(bus.a | bus.b);
            C_MFHI:  res = hi_q;
            C_MFLO:  res = lo_q;
            default: res = '0;
        endcase
    end

    // Unsigned addu/subu never flag overflow; only the trapping forms and lw/sw/beq do.
    assign ovf_en = (bus.ALUop == 2'b00) || (bus.ALUop == 2'b01) ||
                    ((bus.ALUop == 2'b10) &&
                     ((bus.funct == 6'b100000) || (bus.funct == 6'b100010)));

    always_comb begin
        ovf = 1'b0;
        if (ovf_en) begin
            if (ctrl == C_ADD)
                ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            else if (ctrl == C_SUB)
                ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
        end
    end

    assign accept = bus.issue & ~busy;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;
    localparam int CW = $clog2(WIDTH) + 1;

    state_e             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc, quo, mcand;
    logic               op_div, neg_lo, neg_hi, div_zero, done_q;
    logic               start, last_iter, fin, hl_or_md;
    logic               a_neg, b_neg, div_ge;
    logic [WIDTH:0]     mul_sum, shifted, trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    assign start     = accept && (ctrl == C_MULDIV);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:       if (start) state_nxt = bus.funct[1] ? S_DIV : S_MUL;
            S_MUL, S_DIV: if (last_iter) state_nxt = S_FIN;
            S_FIN:        state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        fin  = (state == S_FIN);
    end

    // funct[0] set means the unsigned variant; signed ops iterate on magnitudes.
    assign a_neg   = ~bus.funct[0] & bus.a[WIDTH-1];
    assign b_neg   = ~bus.funct[0] & bus.b[WIDTH-1];
    assign mul_sum = {1'b0, acc} + (quo[0] ? {1'b0, mcand} : '0);
    assign shifted = {acc, quo[WIDTH-1]};
    assign div_ge  = (shifted >= {1'b0, mcand});
    assign trial   = shifted - {1'b0, mcand};
    assign prod    = neg_lo ? -{acc, quo} : {acc, quo};

    // A zero divisor leaves an all-ones quotient, which must not be negated.
    always_comb begin
        if (op_div) begin
            fin_lo = (neg_lo && !div_zero) ? -quo : quo;
            fin_hi = neg_hi ? -acc : acc;
        end else begin
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            acc      <= '0;
            quo      <= '0;
            mcand    <= '0;
            op_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= fin;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt      <= '0;
                        acc      <= '0;
                        quo      <= a_neg ? -bus.a : bus.a;
                        mcand    <= b_neg ? -bus.b : bus.b;
                        op_div   <= bus.funct[1];
                        neg_lo   <= a_neg ^ b_neg;
                        neg_hi   <= bus.funct[1] ? a_neg : (a_neg ^ b_neg);
                        div_zero <= (bus.b == '0);
                    end
                end
                S_MUL: begin
                    acc <= mul_sum[WIDTH:1];
                    quo <= {mul_sum[0], quo[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                end
                S_DIV: begin
                    acc <= div_ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], div_ge};
                    cnt <= cnt + 1'b1;
                end
                S_FIN: cnt <= '0;
                default: ;
            endcase
        end
    end

    assign hl_or_md  = (ctrl == C_MFHI) || (ctrl == C_MFLO) || (ctrl == C_MTHI) ||
                       (ctrl == C_MTLO) || (ctrl == C_MULDIV);
    assign bus.stall = bus.issue & busy & hl_or_md;
    assign bus.done  = done_q;
`else
    assign busy      = 1'b0;
    assign bus.stall = 1'b0;
    assign bus.done  = 1'b0;
`endif

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (accept && (ctrl == C_MTHI)) hi_d = bus.a;
        if (accept && (ctrl == C_MTLO)) lo_d = bus.a;
`ifdef ALU_MULDIV_EN
        if (fin) begin
            hi_d = fin_hi;
            lo_d = fin_lo;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign bus.ALUctrl = ctrl;
    assign bus.result  = res;
    assign bus.zero    = (res == '0);
    assign bus.ovf     = ovf;
    assign bus.busy    = busy;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;

endmodule

// File: doc/alu_exec_md.md
# alu_exec_md

Parametrised execution-stage unit that replaces the combinational ALU-control decoder. It decodes `ALUop`/`funct`, performs single-cycle integer operations on `WIDTH`-bit operands, and owns the HI/LO register pair with an iterative multiply/divide engine. Sits in EX between the ID/EX pipeline register and EX/MEM, and drives `stall` back to the hazard unit while a multiply/divide is in flight.

## Interface
- `WIDTH`, 32: operand and result width; any value ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `issue`  in  1  a valid instruction is in EX this cycle.
- `ALUop`  in  2  00 = add (lw/sw), 01 = sub (beq), 10 = R-type (decode `funct`), 11 = reserved.
- `funct`  in  6  R-type function field.
- `a`, `b`  in  WIDTH  rs and rt operands.
- `ALUctrl`  out  4  decoded operation code, combinational.
- `result`  out  WIDTH  combinational result.
- `zero`  out  1  asserted when `result == 0`.
- `ovf`  out  1  signed overflow, for add and sub only.
- `busy`  out  1  multiply/divide engine not idle.
- `stall`  out  1  `issue & busy & (HI/LO-access op or mul/div op)`.
- `done`  out  1  one-cycle pulse when HI/LO are updated by the engine.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- `ALUctrl` codes:
  - `0000` and, `0001` or, `0010` add, `0011` xor, `0110` sub, `0111` slt, `1000` sltu, `1100` nor.
  - `1001` mfhi, `1010` mflo, `1011` mthi, `1101` mtlo, `1110` mul/div.
  - `1111` invalid.
- R-type `funct` decode:
  - 100000/100001 add/addu; 100010/100011 sub/subu; 100100 and; 100101 or; 100110 xor; 100111 nor; 101010 slt; 101011 sltu.
  - 010000 mfhi; 010001 mthi; 010010 mflo; 010011 mtlo.
  - 011000 mult; 011001 multu; 011010 div; 011011 divu.
  - Any other `funct` → `1111`.
- ALUop 11 → `1111`.
- Invalid ops: `result = 0`, no state change.
- `ovf` is asserted only for funct 100000/100010 and for ALUop 00/01; it is 0 for all other ops.
- slt is signed and sltu is unsigned; both return `{WIDTH-1 zeros, bit}`.
- mfhi/mflo: `result = hi/lo`. mthi/mtlo: `result = 0`.
- HI/LO-access and mul/div ops take effect only when `issue & !busy`.
- mthi/mtlo write `a` into HI/LO at the clock edge.
- Engine FSM:
  - IDLE → MUL or DIV on an accepted mul/div op.
  - MUL/DIV run exactly WIDTH iterations (one bit per cycle, shift-add / restoring), then → FIN.
  - FIN applies sign correction, writes HI/LO, → IDLE.
- Signed ops operate on magnitudes; the product is negated if the operand signs differ; the quotient is negated if the signs differ; the remainder takes the sign of `a`.
- mult/multu: `{hi, lo}` = 2·WIDTH-bit product.
- div/divu: `lo` = quotient, `hi` = remainder.
- Divide by zero: no exception; the iteration still runs. Final `lo = {WIDTH{1'b1}}` and `hi = a`, identical for signed and unsigned.
- Signed MIN / −1: `lo = MIN`, `hi = 0`.
- Single-cycle ALU ops continue to produce results while `busy`.

## Timing
- Reset (asynchronous, any state including mid-operation): FSM = IDLE; `hi`, `lo`, iteration counter and datapath registers cleared to 0; `busy = 0`, `done = 0`, `stall = 0`. Combinational outputs follow their inputs.
- Mul/div accepted in cycle T:
  - `busy` is high from T+1 through T+WIDTH+1.
  - In cycle T+WIDTH+2: `done = 1`, `busy = 0`, and the new `hi`/`lo` are visible. mfhi issued in that cycle returns the new value.
- Total latency is WIDTH+2 cycles; for WIDTH = 32 this is 34.
- mthi/mtlo: new value visible the cycle after issue.
- An issue coinciding with `done` is accepted normally.
- While `stall = 1` the op is ignored; the pipeline holds and re-presents it.

## Configuration
- `ALU_MULDIV_EN` defined:
  - Engine and FSM present as described.
- `ALU_MULDIV_EN` undefined:
  - funct 011000–011011 decode to `1111` (invalid).
  - `busy`, `stall` and `done` are tied to 0; no FSM.
  - HI/LO remain and are accessible via mthi/mtlo/mfhi/mflo.

## Test plan
- Decode sweep (WIDTH = 32): ALUop 00 → `0010`; ALUop 01 → `0110`; every listed funct → its code; funct 000000 and ALUop 11 → `1111` with `result = 0`.
- Arithmetic edges: add `7FFFFFFF + 1` → `80000000`, `ovf = 1`. sub `5 − 5` → `zero = 1`. slt `FFFFFFFF, 1` → 1; sltu same operands → 0. nor `0, 0` → `FFFFFFFF`.
- mult `FFFFFFFE × 3` (−2 × 3) → `hi = FFFFFFFF`, `lo = FFFFFFFA`; multu same operands → `hi = 2`, `lo = FFFFFFFA`. `done` in cycle T+34; `busy` high for exactly 33 cycles.
- div `FFFFFFF9 / 2` (−7 / 2) → `lo = FFFFFFFD`, `hi = FFFFFFFF`. divu `7 / 0` → `lo = FFFFFFFF`, `hi = 7`. div `80000000 / FFFFFFFF` → `lo = 80000000`, `hi = 0`.
- Hazards: mfhi issued at T+5 after a mult → `stall = 1` and HI unchanged; an add issued at T+5 → correct `result` with `stall = 0`; mfhi at T+34 → new HI.
- Async reset asserted at T+10 of a div → all outputs 0 immediately; after release, mtlo `A5A5A5A5` followed by mflo → `A5A5A5A5`.
